fetch_queue: RTL and testbench

// Decoupling FIFO between instruction fetch and the IF/ID pipeline register.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Decoupling FIFO between instruction fetch and the IF/ID pipeline register.
// Fetch pushes {pc, instr} pairs. Decode sees the oldest entry through a
// valid/ready handshake, and its ready signal drives the IF/ID register
// enable. A redirect (mispredict or exception) flushes the whole queue on the
// next edge, which matches the clear behaviour of the IF/ID register.
//
// Parameters
//   DEPTH  entry count (power of 2, >= 2)
//   XLEN   PC width
//   ILEN   instruction word width
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous flush, highest priority after rst
//   in_valid   fetch presents an entry
//   in_ready   queue can accept an entry (not full)
//   in_pc      PC of the incoming instruction
//   in_instr   incoming instruction word
//   out_valid  head entry valid (not empty)
//   out_ready  decode consumes the head entry this cycle
//   out_pc     PC of the head entry (0 when empty)
//   out_instr  instruction word of the head entry (0 when empty)
//   count      number of occupied entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [ILEN-1:0] mem_instr [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full and empty are derived from the occupancy count, so a full queue
    // refuses a push even if decode drains an entry in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry is read straight from storage; an empty queue shows zeros
    // so stale storage never leaks to decode.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = mem_pc[rd_ptr];
            out_instr = mem_instr[rd_ptr];
        end
    end

    // Pointers and count. Flush wins over any push/pop in the same cycle.
    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the write is suppressed on a flush cycle so a
    // discarded push leaves nothing behind.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    // Occupancy bookkeeping must agree with the pointer distance, and an
    // empty queue must present a zero PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (PW'(count) == PW'(wr_ptr - rd_ptr));
            assert (!(out_valid == 1'b0 && out_pc != '0));
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. Stimulus pushes the expected {pc, instr}
// of every entry it expects to be accepted into a scoreboard queue; a
// separate monitor pops and compares on every handshake at the DUT output.
// Status outputs (count, in_ready, out_valid, head) are checked directly
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [CW-1:0]   count;

    int checks   = 0;
    int failures = 0;

    logic [XLEN+ILEN-1:0] sb [$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance past the edge. exp_push records
    // the entry in the scoreboard when the bench expects it to be accepted.
    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy, input logic fl, input logic exp_push);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        if (exp_push) sb.push_back({pc, instr});
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Output monitor: a handshake seen mid-cycle will pop on the next edge
    // unless a flush or reset discards it.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("pop_unexpected", {32'h0, out_pc}, 64'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                checkOutput("pop_pc", {32'h0, out_pc}, {32'h0, e[63:32]});
                checkOutput("pop_instr", {32'h0, out_instr}, {32'h0, e[31:0]});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        rst = 1'b0;

        // Mid-cycle asynchronous reset with a push pending
        $display("[TB] test 1: asynchronous reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40 + 4*i, 32'h50 + i, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_count_before", 64'(count), 64'd3);
        in_valid = 1'b1;
        in_pc    = 32'h4C;
        in_instr = 32'h53;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t1_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t1_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t1_count", 64'(count), 64'd0);
        checkOutput("t1_out_pc", 64'(out_pc), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to capacity, refuse the ninth push, then drain in order
        $display("[TB] test 2: fill, overflow refusal, drain");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h100 + 4*i, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_count_full", 64'(count), 64'd8);
        checkOutput("t2_in_ready_full", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 32'h120, 32'hA8, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_count_after_9th", 64'(count), 64'd8);
        checkOutput("t2_head_pc", 64'(out_pc), 64'h100);
        drain(8);
        checkOutput("t2_count_empty", 64'(count), 64'd0);
        checkOutput("t2_out_valid_empty", 64'(out_valid), 64'd0);
        checkOutput("t2_out_pc_empty", 64'(out_pc), 64'd0);
        checkOutput("t2_sb_drained", 64'(sb.size()), 64'd0);

        // Steady state at count=3 with simultaneous push and pop
        $display("[TB] test 3: concurrent push/pop with wraparound");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h300 + 4*i, 32'hC0 + i, 1'b0, 1'b0, 1'b1);
        for (int i = 3; i < 23; i++) begin
            applyStimulus(1'b1, 32'h300 + 4*i, 32'hC0 + i, 1'b1, 1'b0, 1'b1);
            checkOutput("t3_count_steady", 64'(count), 64'd3);
        end
        drain(3);
        checkOutput("t3_count_empty", 64'(count), 64'd0);
        checkOutput("t3_sb_drained", 64'(sb.size()), 64'd0);

        // Full queue: pop proceeds, push is refused
        $display("[TB] test 4: full with push and pop together");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h500 + 4*i, 32'hE0 + i, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h5F0, 32'hEF, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_count", 64'(count), 64'd7);
        checkOutput("t4_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t4_head_pc", 64'(out_pc), 64'h504);
        drain(7);
        checkOutput("t4_sb_drained", 64'(sb.size()), 64'd0);

        // Flush with push and pop in the same cycle
        $display("[TB] test 5: flush discards concurrent push/pop");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h600 + 4*i, 32'h70 + i, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_count_before", 64'(count), 64'd5);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        checkOutput("t5_flush_cycle_head", 64'(out_pc), 64'h600);
        applyStimulus(1'b1, 32'h999, 32'h99, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h200, 32'h20, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_new_valid", 64'(out_valid), 64'd1);
        checkOutput("t5_new_head", 64'(out_pc), 64'h200);
        checkOutput("t5_new_count", 64'(count), 64'd1);
        drain(1);
        checkOutput("t5_sb_drained", 64'(sb.size()), 64'd0);

        // Single entry through an empty queue with decode always ready
        $display("[TB] test 6: latency through empty queue");
        out_ready = 1'b1;
        #1;
        checkOutput("t6_valid_before", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h400, 32'h44, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_valid_after_push", 64'(out_valid), 64'd1);
        checkOutput("t6_head", 64'(out_pc), 64'h400);
        checkOutput("t6_count_one", 64'(count), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_count_zero", 64'(count), 64'd0);
        checkOutput("t6_valid_zero", 64'(out_valid), 64'd0);
        checkOutput("t6_sb_drained", 64'(sb.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
